// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Opcodes, control bundle, ALU op encodings, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_HALT   = 7'b1111111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC   = 2'b10;
  localparam logic [1:0] ALU_OP_JAL    = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       branch;
    logic       jalr_sel;
    logic       rw_sel;
    logic       lui;
    logic       auipc;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational opcode -> ctrl_t decode with halt/illegal flags.
//               CTRL_UPPER_IMM_EN enables LUI/AUIPC decode.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       is_halt,
  output logic       is_illegal
);

  // HALT and unknown opcodes decode to a bubble; the flags carry their meaning.
  always_comb begin
    ctrl       = CTRL_BUBBLE;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.valid     = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_FUNC;
      end
      OP_I: begin
        ctrl.valid     = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_FUNC;
      end
      OP_LOAD: begin
        ctrl.valid      = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_op     = ALU_OP_ADD;
      end
      OP_STORE: begin
        ctrl.valid     = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      OP_BRANCH: begin
        ctrl.valid  = 1'b1;
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_OP_BRANCH;
      end
      OP_JAL: begin
        ctrl.valid     = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.branch    = 1'b1;
        ctrl.rw_sel    = 1'b1;
        ctrl.alu_op    = ALU_OP_JAL;
      end
      OP_JALR: begin
        ctrl.valid     = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.jalr_sel  = 1'b1;
        ctrl.rw_sel    = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
`ifdef CTRL_UPPER_IMM_EN
      OP_LUI: begin
        ctrl.valid     = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.lui       = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.valid     = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.auipc     = 1'b1;
      end
`else
      OP_LUI,
      OP_AUIPC: begin
        is_illegal = 1'b1;
      end
`endif
      default: begin
        is_illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_unit
// Description : Control pipeline after decode with RUN/DRAIN/HALTED FSM and a
//               saturating illegal-opcode counter. Build macro: CTRL_UPPER_IMM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int N_STAGES  = 3,
  parameter int ILL_CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [6:0]                opcode,
  input  logic                      instr_valid,
  input  logic                      stall,
  input  logic                      flush,
  output ctrl_t [N_STAGES-1:0]      stage_ctrl,
  output logic                      fetch_en,
  output logic                      halted,
  output logic                      illegal,
  output logic [ILL_CNT_W-1:0]      illegal_cnt
);

  localparam int DRAIN_W = $clog2(N_STAGES + 1);

  ctrl_t                 dec_ctrl;
  logic                  dec_halt;
  logic                  dec_illegal;
  logic                  accept;

  ctrl_t [N_STAGES-1:0]  stage_d, stage_q;
  state_t                state_d, state_q;
  logic [DRAIN_W-1:0]    drain_d, drain_q;
  logic                  illegal_d, illegal_q;
  logic [ILL_CNT_W-1:0]  ill_cnt_d, ill_cnt_q;

  ctrl_decode u_decode (
    .opcode     (opcode),
    .ctrl       (dec_ctrl),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  // flush and stall both block acceptance, so flush wins trivially
  assign accept = instr_valid && !stall && !flush && (state_q == RUN);

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = accept ? dec_ctrl : CTRL_BUBBLE;
    for (int k = 1; k < N_STAGES; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      RUN: begin
        if (accept && dec_halt) begin
          state_d = DRAIN;
          drain_d = DRAIN_W'(N_STAGES);
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_W'(1)) begin
          state_d = HALTED;
          drain_d = '0;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
        drain_d = '0;
      end
    endcase
  end

  always_comb begin
    illegal_d = accept && dec_illegal;
    ill_cnt_d = ill_cnt_q;
    if (illegal_d && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
      ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q   <= '0;
      state_q   <= RUN;
      drain_q   <= '0;
      illegal_q <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      stage_q   <= stage_d;
      state_q   <= state_d;
      drain_q   <= drain_d;
      illegal_q <= illegal_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign stage_ctrl  = stage_q;
  assign fetch_en    = (state_q == RUN);
  assign halted      = (state_q == HALTED);
  assign illegal     = illegal_q;
  assign illegal_cnt = ill_cnt_q;

endmodule
`default_nettype wire
